// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control-register chain.
package pipe_ctrl_pkg;

  // Stall timer states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } timer_state_e;

  // Width of the retired-instruction counter.
  localparam int RETIRE_W = 32;

  // Valid bit of a bubble; a bubble's control bundle is always all zeros.
  localparam logic BUBBLE_VALID = 1'b0;

  // An instruction leaves the last stage when it is valid, not held and not flushed.
  function automatic logic retire_fire(input logic valid, input logic hold, input logic flush);
    return valid & ~hold & ~flush;
  endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// Upstream handshake between the control mux and stage 0 of the chain.
interface ctrl_pipe_chain_if #(
  parameter int CTRL_W = 8
) ();

  logic [CTRL_W-1:0] in_ctrl;
  logic              in_valid;
  logic              in_ready;

  // Source side: the control mux presents bundles and watches in_ready.
  modport master (
    output in_ctrl,
    output in_valid,
    input  in_ready
  );

  // Sink side: the pipeline chain consumes bundles and drives in_ready.
  modport slave (
    input  in_ctrl,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/stall_timer.sv
// Multi-cycle stall timer for load-use interlocks: holds stage 0 for
// stall_len cycles starting the cycle after a request; requests while
// already stalling are ignored.
module stall_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_req,
  input  logic [LEN_W-1:0] stall_len,
  output logic             timer_busy
);

  timer_state_e     state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             busy_q;

  // FSM with down-counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stall_req && (stall_len != '0)) begin
            cnt_q   <= stall_len;
            state_q <= ST_STALL;
            busy_q  <= 1'b1;
          end
        end
        ST_STALL: begin
          if (cnt_q == LEN_W'(1)) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign timer_busy = busy_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Chain of pipeline control registers (ID/EX .. MEM/WB) carrying a control
// bundle and valid bit, with per-stage stall/flush, bubble insertion,
// a load-use stall timer and a retired-instruction counter.
module ctrl_pipe_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int STAGES = 3,
  parameter int LEN_W  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  ctrl_pipe_chain_if.slave           in_if,
  input  logic [STAGES-1:0]          stall,
  input  logic [STAGES-1:0]          flush,
  input  logic                       stall_req,
  input  logic [LEN_W-1:0]           stall_len,
  output logic [STAGES*CTRL_W-1:0]   stage_ctrl,
  output logic [STAGES-1:0]          stage_valid,
  output logic                       timer_busy,
  output logic [RETIRE_W-1:0]        retired_count
);

  logic [STAGES-1:0]   stall_eff;
  logic [STAGES-1:0]   hold;
  logic                retire_w;
  logic [RETIRE_W-1:0] retired_q;

  stall_timer #(
    .LEN_W(LEN_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .stall_req  (stall_req),
    .stall_len  (stall_len),
    .timer_busy (timer_busy)
  );

  // The timer only ever stalls stage 0.
  always_comb begin
    stall_eff    = stall;
    stall_eff[0] = stall[0] | timer_busy;
  end

  // A stall freezes its own stage and every stage upstream of it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | stall_eff[i];
      hold[i] = acc;
    end
  end

  assign in_if.in_ready = ~hold[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Next-state selection: flush, then hold, then load from upstream.
    always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      if (flush[gi]) begin
        valid_d = BUBBLE_VALID;
        ctrl_d  = '0;
      end else if (!hold[gi]) begin
        if (gi == 0) begin
          valid_d = in_if.in_valid;
          ctrl_d  = in_if.in_valid ? in_if.in_ctrl : '0;
        end else if (hold[(gi == 0) ? 0 : gi - 1]) begin
          valid_d = BUBBLE_VALID;
          ctrl_d  = '0;
        end else begin
          valid_d = stage_valid[(gi == 0) ? 0 : gi - 1];
          ctrl_d  = stage_ctrl[((gi == 0) ? 0 : gi - 1) * CTRL_W +: CTRL_W];
        end
      end
    end

    // Stage register; a bubble always carries an all-zero bundle.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= BUBBLE_VALID;
        ctrl_q  <= '0;
      end else begin
        valid_q <= valid_d;
        ctrl_q  <= ctrl_d;
      end
    end

    assign stage_valid[gi]                   = valid_q;
    assign stage_ctrl[gi*CTRL_W +: CTRL_W]   = ctrl_q;
  end

  assign retire_w = retire_fire(stage_valid[STAGES-1], hold[STAGES-1], flush[STAGES-1]);

  // Retired-instruction counter, wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire_w) begin
      retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  assign retired_count = retired_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain (STAGES=3, CTRL_W=8, LEN_W=3).
module tb_ctrl_pipe_chain;

  logic        clk;
  logic        reset;
  logic [2:0]  stall;
  logic [2:0]  flush;
  logic        stall_req;
  logic [2:0]  stall_len;
  logic [23:0] stage_ctrl;
  logic [2:0]  stage_valid;
  logic        timer_busy;
  logic [31:0] retired_count;

  int tests_run;
  int tests_failed;
  int model_retired;
  logic [7:0] sb[$];

  ctrl_pipe_chain_if #(.CTRL_W(8)) pin ();

  ctrl_pipe_chain #(
    .CTRL_W(8),
    .STAGES(3),
    .LEN_W (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_if         (pin),
    .stall         (stall),
    .flush         (flush),
    .stall_req     (stall_req),
    .stall_len     (stall_len),
    .stage_ctrl    (stage_ctrl),
    .stage_valid   (stage_valid),
    .timer_busy    (timer_busy),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Scoreboard: push captured bundles, pop and compare on retirement.
  always @(negedge clk) begin
    logic [7:0] exp_c;
    if (!reset) begin
      if (stage_valid[2] && !stall[2] && !flush[2]) begin
        model_retired++;
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_retire: stage2 retired %h, required no instruction (queue empty)", stage_ctrl[23:16]);
        end else begin
          exp_c = sb.pop_front();
          if (stage_ctrl[23:16] !== exp_c) begin
            tests_failed++;
            $display("FAIL sb_retire: stage2 ctrl %h, required %h", stage_ctrl[23:16], exp_c);
          end else begin
            $display("[TB] retire ctrl=%h ok", exp_c);
          end
        end
      end
      if (pin.in_valid && pin.in_ready && !flush[0]) sb.push_back(pin.in_ctrl);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (stage_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_valid: got %b, required 000", stage_valid); end
    tests_run++;
    if (stage_ctrl !== 24'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h, required 000000", stage_ctrl); end
    tests_run++;
    if (timer_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", timer_busy); end
    tests_run++;
    if (retired_count !== 32'd0) begin tests_failed++; $display("FAIL reset_retired: got %0d, required 0", retired_count); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (pin.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b, required 1", pin.in_ready); end
    stall = 3'b001;
    #1;
    tests_run++;
    if (pin.in_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_stall0: got %b, required 0", pin.in_ready); end
    stall = 3'b000;
    $display("[TB] test_reset done");
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3];
    logic [7:0] exp2 [3];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      pin.in_valid = 1'b1;
      pin.in_ctrl  = vals[i];
      tick();
    end
    pin.in_valid = 1'b0;
    pin.in_ctrl  = 8'h00;
    tests_run++;
    if (stage_ctrl !== 24'hA1B2C3 || stage_valid !== 3'b111) begin
      tests_failed++;
      $display("FAIL stream_fill: ctrl %h valid %b, required A1B2C3 111", stage_ctrl, stage_valid);
    end
    exp2[0] = 8'hB2; exp2[1] = 8'hC3; exp2[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (stage_ctrl[23:16] !== exp2[i] || stage_valid[2] !== (i < 2)) begin
        tests_failed++;
        $display("FAIL stream_stage2[%0d]: ctrl %h valid %b, required %h %b", i, stage_ctrl[23:16], stage_valid[2], exp2[i], (i < 2));
      end
    end
    tests_run++;
    if (retired_count !== 32'd3) begin tests_failed++; $display("FAIL stream_retired: got %0d, required 3", retired_count); end
    $display("[TB] test_streaming done");
  endtask

  task automatic test_middle_stall();
    logic [7:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      pin.in_valid = 1'b1;
      pin.in_ctrl  = vals[i];
      tick();
    end
    pin.in_ctrl = 8'hD4;
    stall = 3'b010;
    #1;
    tests_run++;
    if (pin.in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready: got %b, required 0", pin.in_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (stage_ctrl !== 24'h00B2C3 || stage_valid !== 3'b011) begin
        tests_failed++;
        $display("FAIL mid_hold[%0d]: ctrl %h valid %b, required 00B2C3 011", c, stage_ctrl, stage_valid);
      end
    end
    stall = 3'b000;
    tick();
    pin.in_valid = 1'b0;
    pin.in_ctrl  = 8'h00;
    tests_run++;
    if (stage_ctrl !== 24'hB2C3D4 || stage_valid !== 3'b111) begin
      tests_failed++;
      $display("FAIL mid_resume: ctrl %h valid %b, required B2C3D4 111", stage_ctrl, stage_valid);
    end
    tick(); tick(); tick();
    tests_run++;
    if (retired_count !== model_retired) begin tests_failed++; $display("FAIL mid_retired: got %0d, required %0d", retired_count, model_retired); end
    $display("[TB] test_middle_stall done");
  endtask

  task automatic test_timer();
    logic [7:0] cur;
    logic       cap;
    logic       exp_busy;
    logic       exp_v1;
    pin.in_valid = 1'b1;
    pin.in_ctrl  = 8'h0F;
    tick();
    cur = 8'h10;
    pin.in_ctrl = cur;
    for (int i = 0; i < 8; i++) begin
      stall_req = (i == 0) || (i == 2);
      stall_len = (i == 0) ? 3'd3 : 3'd7;
      cap = pin.in_ready;
      tick();
      stall_req = 1'b0;
      if (cap) begin
        cur = cur + 8'h01;
        pin.in_ctrl = cur;
      end
      exp_busy = (i + 1 >= 1) && (i + 1 <= 3);
      exp_v1   = !((i + 1 >= 2) && (i + 1 <= 4));
      tests_run++;
      if (timer_busy !== exp_busy) begin tests_failed++; $display("FAIL timer_busy[%0d]: got %b, required %b", i + 1, timer_busy, exp_busy); end
      tests_run++;
      if (pin.in_ready !== !exp_busy) begin tests_failed++; $display("FAIL timer_ready[%0d]: got %b, required %b", i + 1, pin.in_ready, !exp_busy); end
      tests_run++;
      if (stage_valid[1] !== exp_v1 || (!exp_v1 && stage_ctrl[15:8] !== 8'h00)) begin
        tests_failed++;
        $display("FAIL timer_s1[%0d]: valid %b ctrl %h, required valid %b", i + 1, stage_valid[1], stage_ctrl[15:8], exp_v1);
      end
    end
    pin.in_valid = 1'b0;
    pin.in_ctrl  = 8'h00;
    tick(); tick(); tick(); tick();
    tests_run++;
    if (retired_count !== model_retired) begin tests_failed++; $display("FAIL timer_retired: got %0d, required %0d", retired_count, model_retired); end
    $display("[TB] test_timer done");
  endtask

  task automatic test_flush_timer();
    pin.in_valid = 1'b1;
    pin.in_ctrl  = 8'h33;
    stall_req    = 1'b1;
    stall_len    = 3'd2;
    flush        = 3'b001;
    tick();
    pin.in_valid = 1'b0;
    pin.in_ctrl  = 8'h00;
    stall_req    = 1'b0;
    flush        = 3'b000;
    tests_run++;
    if (stage_valid[0] !== 1'b0 || stage_ctrl[7:0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL flush0_s0: valid %b ctrl %h, required 0 00", stage_valid[0], stage_ctrl[7:0]);
    end
    tests_run++;
    if (timer_busy !== 1'b1) begin tests_failed++; $display("FAIL flush0_busy: got %b, required 1", timer_busy); end
    tick();
    tick();
    tests_run++;
    if (timer_busy !== 1'b0) begin tests_failed++; $display("FAIL flush0_done: got %b, required 0", timer_busy); end
    $display("[TB] test_flush_timer done");
  endtask

  task automatic test_flush_vs_stall();
    logic [7:0] vals [3];
    int saved;
    vals[0] = 8'h5A; vals[1] = 8'h6B; vals[2] = 8'h7C;
    for (int i = 0; i < 3; i++) begin
      pin.in_valid = 1'b1;
      pin.in_ctrl  = vals[i];
      tick();
    end
    pin.in_valid = 1'b0;
    pin.in_ctrl  = 8'h00;
    stall = 3'b100;
    flush = 3'b100;
    #1;
    tests_run++;
    if (pin.in_ready !== 1'b0) begin tests_failed++; $display("FAIL fvs_ready: got %b, required 0", pin.in_ready); end
    saved = model_retired;
    tick();
    void'(sb.pop_front());
    flush = 3'b000;
    tests_run++;
    if (stage_ctrl !== 24'h006B7C || stage_valid !== 3'b011) begin
      tests_failed++;
      $display("FAIL fvs_bubble: ctrl %h valid %b, required 006B7C 011", stage_ctrl, stage_valid);
    end
    tests_run++;
    if (retired_count !== saved) begin tests_failed++; $display("FAIL fvs_retired: got %0d, required %0d", retired_count, saved); end
    tick();
    tests_run++;
    if (stage_ctrl !== 24'h006B7C || stage_valid !== 3'b011) begin
      tests_failed++;
      $display("FAIL fvs_held_bubble: ctrl %h valid %b, required 006B7C 011", stage_ctrl, stage_valid);
    end
    stall = 3'b000;
    tick(); tick(); tick();
    tests_run++;
    if (retired_count !== model_retired) begin tests_failed++; $display("FAIL fvs_drain: got %0d, required %0d", retired_count, model_retired); end
    $display("[TB] test_flush_vs_stall done");
  endtask

  task automatic test_invalid_mask();
    pin.in_valid = 1'b0;
    pin.in_ctrl  = 8'hFF;
    tick();
    tests_run++;
    if (stage_valid[0] !== 1'b0 || stage_ctrl[7:0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL invalid_mask: valid %b ctrl %h, required 0 00", stage_valid[0], stage_ctrl[7:0]);
    end
    pin.in_ctrl = 8'h00;
    $display("[TB] test_invalid_mask done");
  endtask

  task automatic test_reset_mid();
    pin.in_valid = 1'b1;
    pin.in_ctrl  = 8'h81;
    tick();
    pin.in_ctrl  = 8'h82;
    tick();
    pin.in_ctrl  = 8'h83;
    stall_req    = 1'b1;
    stall_len    = 3'd7;
    tick();
    stall_req    = 1'b0;
    pin.in_valid = 1'b0;
    pin.in_ctrl  = 8'h00;
    tests_run++;
    if (stage_valid !== 3'b111 || timer_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_pre: valid %b busy %b, required 111 1", stage_valid, timer_busy);
    end
    reset = 1'b1;
    sb.delete();
    tick();
    model_retired = 0;
    tests_run++;
    if (stage_valid !== 3'b000 || stage_ctrl !== 24'h0) begin
      tests_failed++;
      $display("FAIL rmid_stages: valid %b ctrl %h, required 000 000000", stage_valid, stage_ctrl);
    end
    tests_run++;
    if (timer_busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %b, required 0", timer_busy); end
    tests_run++;
    if (retired_count !== 32'd0) begin tests_failed++; $display("FAIL rmid_retired: got %0d, required 0", retired_count); end
    reset = 1'b0;
    tick();
    tests_run++;
    if (timer_busy !== 1'b0 || pin.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_after: busy %b ready %b, required 0 1", timer_busy, pin.in_ready);
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    model_retired = 0;
    reset         = 1'b1;
    stall         = 3'b000;
    flush         = 3'b000;
    stall_req     = 1'b0;
    stall_len     = 3'd0;
    pin.in_valid  = 1'b0;
    pin.in_ctrl   = 8'h00;
    test_reset();
    test_streaming();
    test_middle_stall();
    test_timer();
    test_flush_timer();
    test_flush_vs_stall();
    test_invalid_mask();
    test_reset_mid();
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL sb_leftover: %0d entries, required 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
